// File: rtl/gpu_ucode_sequencer.sv
// Microcode sequencer: walks a synchronous ROM from an entry address, strobes datapath micro-ops
// and resolves wait/repeat/continue/end control ops. Optional wait watchdog: GPU_USEQ_WDOG_EN.
module gpu_ucode_sequencer #(
  parameter int UADDR_W     = 8,
  parameter int REP_W       = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dispatch_i,
  input  logic [UADDR_W-1:0] entry_addr_i,
  input  logic [REP_W-1:0]   repeat_cnt_i,
  input  logic               abort_i,
  output logic [UADDR_W-1:0] rom_addr_o,
  input  logic [5:0]         rom_data_i,
  input  logic               mau_all_done_i,
  input  logic               mau_any_done_i,
  input  logic               fb_ready_i,
  input  logic               ldu_done_i,
  input  logic               cpu_go_i,
  input  logic               dtcu_done_i,
  input  logic               continue_i,
  output logic               uop_valid_o,
  output logic [5:0]         uop_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [5:0] OP_ENDMICRO     = 6'd0;
  localparam logic [5:0] OP_WAIT_ALL_MAU = 6'd16;
  localparam logic [5:0] OP_WAIT_ANY_MAU = 6'd17;
  localparam logic [5:0] OP_WAIT_FB      = 6'd18;
  localparam logic [5:0] OP_WAIT_LDU     = 6'd19;
  localparam logic [5:0] OP_WAIT_START   = 6'd20;
  localparam logic [5:0] OP_WAIT_DTCU    = 6'd21;
  localparam logic [5:0] OP_WAIT_CYCLE   = 6'd22;
  localparam logic [5:0] OP_REPEAT       = 6'd23;
  localparam logic [5:0] OP_CONT_OR_END  = 6'd35;

`ifdef GPU_USEQ_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_STALL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [UADDR_W-1:0] upc_q, upc_d, loop_q, loop_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [5:0]         uop_q, uop_d, wait_op_q, wait_op_d, cond_op;
  logic               err_q, err_d, cond_hit, is_dp;
  logic [WD_W-1:0]    wdog_q, wdog_d;

  // In WAIT the condition comes from the latched op; in EXEC straight from the ROM word.
  always_comb begin
    cond_op  = (state_q == S_WAIT) ? wait_op_q : rom_data_i;
    cond_hit = 1'b0;
    case (cond_op)
      OP_WAIT_ALL_MAU: cond_hit = mau_all_done_i;
      OP_WAIT_ANY_MAU: cond_hit = mau_any_done_i;
      OP_WAIT_FB:      cond_hit = fb_ready_i;
      OP_WAIT_LDU:     cond_hit = ldu_done_i;
      OP_WAIT_START:   cond_hit = cpu_go_i;
      OP_WAIT_DTCU:    cond_hit = dtcu_done_i;
      default:         cond_hit = 1'b0;
    endcase
  end

  assign is_dp = ((rom_data_i >= 6'd1)  && (rom_data_i <= 6'd15)) ||
                 ((rom_data_i >= 6'd24) && (rom_data_i <= 6'd34)) ||
                 (rom_data_i == 6'd36);

  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    loop_d      = loop_q;
    rep_d       = rep_q;
    uop_d       = uop_q;
    wait_op_d   = wait_op_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    uop_valid_o = 1'b0;
    done_o      = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dispatch_i) begin
            upc_d   = entry_addr_i;
            loop_d  = entry_addr_i;
            rep_d   = repeat_cnt_i;
            err_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_EXEC;
        S_EXEC: begin
          if (is_dp) begin
            uop_valid_o = 1'b1;
            uop_d       = rom_data_i;
            upc_d       = upc_q + UADDR_W'(1);
            state_d     = S_FETCH;
          end else begin
            case (rom_data_i)
              OP_WAIT_ALL_MAU, OP_WAIT_ANY_MAU, OP_WAIT_FB,
              OP_WAIT_LDU, OP_WAIT_START, OP_WAIT_DTCU: begin
                if (cond_hit) begin
                  upc_d   = upc_q + UADDR_W'(1);
                  state_d = S_FETCH;
                end else begin
                  wait_op_d = rom_data_i;
                  wdog_d    = '0;
                  state_d   = S_WAIT;
                end
              end
              OP_WAIT_CYCLE: state_d = S_STALL;
              OP_REPEAT: begin
                if (rep_q != '0) begin
                  rep_d = rep_q - REP_W'(1);
                  upc_d = loop_q;
                end else begin
                  upc_d = upc_q + UADDR_W'(1);
                end
                state_d = S_FETCH;
              end
              OP_CONT_OR_END: begin
                if (continue_i) begin
                  upc_d   = upc_q + UADDR_W'(1);
                  state_d = S_FETCH;
                end else begin
                  state_d = S_DONE;
                end
              end
              OP_ENDMICRO: state_d = S_DONE;
              default: begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end
            endcase
          end
        end
        S_WAIT: begin
          if (cond_hit) begin
            upc_d   = upc_q + UADDR_W'(1);
            state_d = S_FETCH;
          end else if (WDOG_EN && (wdog_q == WD_W'(WDOG_CYCLES - 1))) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        S_STALL: begin
          upc_d   = upc_q + UADDR_W'(1);
          state_d = S_FETCH;
        end
        S_DONE: begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      upc_q     <= '0;
      loop_q    <= '0;
      rep_q     <= '0;
      uop_q     <= OP_ENDMICRO;
      wait_op_q <= '0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      loop_q    <= loop_d;
      rep_q     <= rep_d;
      uop_q     <= uop_d;
      wait_op_q <= wait_op_d;
      err_q     <= err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign rom_addr_o = upc_q;
  assign uop_o      = uop_valid_o ? rom_data_i : uop_q;
  assign busy_o     = (state_q != S_IDLE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Bench for gpu_ucode_sequencer: table vectors, directed corner sequences and random programs
// checked against a cycle-count interpreter of the microcode rules.
module tb_gpu_ucode_sequencer;
  localparam int WDOG = 16;
  localparam int OP_END = 0, OP_START_MAU4 = 1, OP_INC_PC_A = 6, OP_SET_COLOUR = 24;
  localparam int OP_DRAW_PIXEL = 34, OP_WAIT_ALL = 16, OP_WAIT_FB = 18, OP_WAIT_LDU = 19;
  localparam int OP_WAIT_CYCLE = 22, OP_REPEAT = 23, OP_CONT = 35;

  logic       clk = 1'b0, rst = 1'b1;
  logic       dispatch_i = 1'b0, abort_i = 1'b0, continue_i = 1'b0;
  logic [7:0] entry_addr_i = '0, repeat_cnt_i = '0, rom_addr_o;
  logic [5:0] rom_data_i, uop_o;
  logic       mau_all_done_i = 1'b1, mau_any_done_i = 1'b1, fb_ready_i = 1'b1;
  logic       ldu_done_i = 1'b1, cpu_go_i = 1'b1, dtcu_done_i = 1'b1;
  logic       uop_valid_o, busy_o, done_o, err_o;
  logic [5:0] rom [0:255];

  gpu_ucode_sequencer #(.UADDR_W(8), .REP_W(8), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .dispatch_i(dispatch_i), .entry_addr_i(entry_addr_i),
    .repeat_cnt_i(repeat_cnt_i), .abort_i(abort_i), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .mau_all_done_i(mau_all_done_i), .mau_any_done_i(mau_any_done_i),
    .fb_ready_i(fb_ready_i), .ldu_done_i(ldu_done_i), .cpu_go_i(cpu_go_i),
    .dtcu_done_i(dtcu_done_i), .continue_i(continue_i), .uop_valid_o(uop_valid_o),
    .uop_o(uop_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  int nvec = 0, nmis = 0;
  int exp_t[$], exp_op[$];
  int exp_done, exp_err;
  int obs_t[$], obs_op[$], obs_busy[$], obs_addr[$], obs_err[$];
  int got_done, got_ndone, got_err, got_busy_after;

  typedef struct {
    int op; int rep; bit cont; int nstrobe; int done_at; int err;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle-count interpreter: relative to the dispatch cycle (t=0) the first op executes at t=2;
  // every pass back through the ROM costs 2 cycles, a stall costs 3, termination lands 1 later.
  task automatic model(input int entry, input int rep, input bit cont);
    int pc, r, t, op;
    pc = entry; r = rep; t = 2;
    exp_t.delete(); exp_op.delete(); exp_done = -1; exp_err = 0;
    for (int step = 0; step < 4000; step++) begin
      op = int'(rom[pc]);
      if ((op >= 1 && op <= 15) || (op >= 24 && op <= 34) || op == 36) begin
        exp_t.push_back(t); exp_op.push_back(op); pc = (pc + 1) % 256; t += 2;
      end else if (op >= 16 && op <= 21) begin
        pc = (pc + 1) % 256; t += 2;
      end else if (op == OP_WAIT_CYCLE) begin
        pc = (pc + 1) % 256; t += 3;
      end else if (op == OP_REPEAT) begin
        if (r > 0) begin r--; pc = entry; end
        else pc = (pc + 1) % 256;
        t += 2;
      end else if (op == OP_CONT && cont) begin
        pc = (pc + 1) % 256; t += 2;
      end else begin
        exp_err = (op > 36) ? 1 : 0;
        exp_done = t + 1;
        return;
      end
    end
  endtask

  task automatic run(input int entry, input int rep, input bit cont, input bit hold_disp,
                     input int rise_t, input int abort_t, input int limit);
    obs_t.delete(); obs_op.delete(); obs_busy.delete(); obs_addr.delete(); obs_err.delete();
    got_done = -1; got_ndone = 0; got_err = -1; got_busy_after = -1;
    @(posedge clk); #1;
    entry_addr_i = entry[7:0]; repeat_cnt_i = rep[7:0]; continue_i = cont; dispatch_i = 1'b1;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      obs_busy.push_back(int'(busy_o)); obs_addr.push_back(int'(rom_addr_o));
      obs_err.push_back(int'(err_o));
      if (uop_valid_o) begin obs_t.push_back(t); obs_op.push_back(int'(uop_o)); end
      if (done_o) begin
        got_ndone++; got_done = t; got_err = int'(err_o);
        if (hold_disp) dispatch_i = 1'b0;
      end
      if (got_done >= 0 && t == got_done + 1) begin got_busy_after = int'(busy_o); break; end
      @(posedge clk); #1;
      if (!hold_disp) dispatch_i = 1'b0;
      if (t + 1 == rise_t) mau_all_done_i = 1'b1;
      abort_i = (t + 1 == abort_t);
    end
    dispatch_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    chk({tag, "_nstrobe"}, obs_t.size(), exp_t.size());
    n = (obs_t.size() < exp_t.size()) ? obs_t.size() : exp_t.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_strobe_t"}, obs_t[i], exp_t[i]);
      chk({tag, "_strobe_op"}, obs_op[i], exp_op[i]);
    end
    chk({tag, "_done_at"}, got_done, exp_done);
    chk({tag, "_ndone"}, got_ndone, 1);
    chk({tag, "_err"}, got_err, exp_err);
    chk({tag, "_busy_after"}, got_busy_after, 0);
  endtask

  task automatic run_model(input string tag, input int entry, input int rep, input bit cont,
                           input bit hold);
    model(entry, rep, cont);
    run(entry, rep, cont, hold, -1, -1, (exp_done < 0) ? 50 : exp_done + 3);
    check_model(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int entry, len, sel, d, op;
    for (int i = 0; i < 256; i++) rom[i] = 6'd0;
    tbl[0]  = '{6,  0, 1'b0, 1, 5, 0};
    tbl[1]  = '{36, 0, 1'b0, 1, 5, 0};
    tbl[2]  = '{15, 0, 1'b0, 1, 5, 0};
    tbl[3]  = '{24, 0, 1'b0, 1, 5, 0};
    tbl[4]  = '{0,  0, 1'b0, 0, 3, 0};
    tbl[5]  = '{16, 0, 1'b0, 0, 5, 0};
    tbl[6]  = '{21, 0, 1'b0, 0, 5, 0};
    tbl[7]  = '{22, 0, 1'b0, 0, 6, 0};
    tbl[8]  = '{23, 0, 1'b0, 0, 5, 0};
    tbl[9]  = '{23, 1, 1'b0, 0, 7, 0};
    tbl[10] = '{35, 0, 1'b1, 0, 5, 0};
    tbl[11] = '{35, 0, 1'b0, 0, 3, 0};
    tbl[12] = '{37, 0, 1'b0, 0, 3, 1};
    tbl[13] = '{63, 0, 1'b0, 0, 3, 1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(uop_valid_o), 0);
    chk("rst_uop", int'(uop_o), 0);
    chk("rst_addr", int'(rom_addr_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);

    foreach (tbl[i]) begin
      rom[8'h80] = tbl[i].op[5:0]; rom[8'h81] = 6'd0;
      run(8'h80, tbl[i].rep, tbl[i].cont, 1'b0, -1, -1, 12);
      chk("tbl_nstrobe", obs_t.size(), tbl[i].nstrobe);
      if (tbl[i].nstrobe > 0 && obs_t.size() > 0) begin
        chk("tbl_strobe_t", obs_t[0], 2);
        chk("tbl_strobe_op", obs_op[0], tbl[i].op);
      end
      chk("tbl_done_at", got_done, tbl[i].done_at);
      chk("tbl_err", got_err, tbl[i].err);
    end

    // Two-op program with dispatch held high throughout: re-dispatch must be ignored.
    rom[8'h10] = 6'(OP_INC_PC_A); rom[8'h11] = 6'(OP_DRAW_PIXEL); rom[8'h12] = 6'd0;
    run_model("tp1", 8'h10, 0, 1'b0, 1'b1);
    chk("tp1_done_at", got_done, 7);
    if (obs_t.size() == 2) chk("tp1_gap", obs_t[1] - obs_t[0], 2);
    else chk("tp1_count", obs_t.size(), 2);
    @(negedge clk);
    chk("tp1_idle_busy", int'(busy_o), 0);
    chk("tp1_uop_hold", int'(uop_o), OP_DRAW_PIXEL);

    rom[8'h30] = 6'(OP_START_MAU4); rom[8'h31] = 6'(OP_WAIT_ALL); rom[8'h32] = 6'd0;
    mau_all_done_i = 1'b0;
    run(8'h30, 0, 1'b0, 1'b0, 25, -1, 35);
    chk("wait_nstrobe", obs_t.size(), 1);
    chk("wait_done_at", got_done, 28);
    if (obs_addr.size() > 26) begin
      chk("wait_addr_held", obs_addr[25], 8'h31);
      chk("wait_addr_fetch", obs_addr[26], 8'h32);
    end else chk("wait_trace_len", obs_addr.size(), 27);

    rom[8'h20] = 6'(OP_SET_COLOUR); rom[8'h21] = 6'(OP_REPEAT); rom[8'h22] = 6'd0;
    run_model("rep3", 8'h20, 3, 1'b0, 1'b0);
    chk("rep3_count", obs_t.size(), 4);
    chk("rep3_done_at", got_done, 19);

    rom[8'h60] = 6'(OP_INC_PC_A); rom[8'h61] = 6'(OP_CONT);
    rom[8'h62] = 6'(OP_DRAW_PIXEL); rom[8'h63] = 6'd0;
    run_model("cont0", 8'h60, 0, 1'b0, 1'b0);
    chk("cont0_count", obs_t.size(), 1);
    run_model("cont1", 8'h60, 0, 1'b1, 1'b0);
    chk("cont1_count", obs_t.size(), 2);

    rom[8'hFF] = 6'(OP_INC_PC_A); rom[8'h00] = 6'(OP_DRAW_PIXEL); rom[8'h01] = 6'd0;
    run_model("wrap", 8'hFF, 0, 1'b0, 1'b0);

    rom[8'h70] = 6'd50;
    run(8'h70, 0, 1'b0, 1'b0, -1, -1, 10);
    chk("ill_done_at", got_done, 3);
    chk("ill_err", got_err, 1);
    @(negedge clk);
    chk("ill_err_sticky", int'(err_o), 1);
    run(8'h10, 0, 1'b0, 1'b0, -1, -1, 12);
    if (obs_err.size() > 1) chk("ill_err_cleared", obs_err[1], 0);
    else chk("ill_trace_len", obs_err.size(), 2);

    run(8'h70, 0, 1'b0, 1'b0, -1, -1, 10);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_idle_err", int'(err_o), 0);

    fb_ready_i = 1'b0;
    rom[8'h40] = 6'(OP_WAIT_FB); rom[8'h41] = 6'd0;
    run(8'h40, 0, 1'b0, 1'b0, -1, 6, 12);
    chk("abort_wait_ndone", got_ndone, 0);
    if (obs_busy.size() > 7) begin
      chk("abort_wait_busy_before", obs_busy[6], 1);
      chk("abort_wait_busy_after", obs_busy[7], 0);
    end else chk("abort_trace_len", obs_busy.size(), 8);

    rom[8'h48] = 6'(OP_INC_PC_A); rom[8'h49] = 6'd0;
    run(8'h48, 0, 1'b0, 1'b0, -1, 2, 10);
    chk("abort_exec_nstrobe", obs_t.size(), 0);
    chk("abort_exec_ndone", got_ndone, 0);
    rom[8'h4C] = 6'd0;
    run(8'h4C, 0, 1'b0, 1'b0, -1, 3, 8);
    chk("abort_done_ndone", got_ndone, 0);

    rom[8'h44] = 6'(OP_INC_PC_A); rom[8'h45] = 6'(OP_WAIT_FB);
    run(8'h44, 0, 1'b0, 1'b0, -1, -1, 8);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_addr", int'(rom_addr_o), 0);
    chk("rst_mid_uop", int'(uop_o), 0);
    chk("rst_mid_valid", int'(uop_valid_o), 0);
    fb_ready_i = 1'b1;

    ldu_done_i = 1'b0;
    rom[8'h50] = 6'(OP_WAIT_LDU); rom[8'h51] = 6'd0;
`ifdef GPU_USEQ_WDOG_EN
    run(8'h50, 0, 1'b0, 1'b0, -1, -1, 26);
    chk("wdog_done_at", got_done, 19);
    chk("wdog_err", got_err, 1);
    chk("wdog_ndone", got_ndone, 1);
`else
    run(8'h50, 0, 1'b0, 1'b0, -1, -1, 40);
    chk("nowdog_ndone", got_ndone, 0);
    chk("nowdog_busy", obs_busy[39], 1);
    chk("nowdog_err", obs_err[39], 0);
    @(posedge clk); #1 abort_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0;
`endif
    ldu_done_i = 1'b1;

    for (int k = 0; k < 25; k++) begin
      entry = int'($urandom_range(0, 255));
      len = int'($urandom_range(1, 8));
      for (int j = 0; j < len; j++) begin
        sel = int'($urandom_range(0, 99));
        if (sel < 50) begin
          d = int'($urandom_range(0, 26));
          op = (d < 15) ? d + 1 : (d < 26) ? d - 15 + 24 : 36;
        end else if (sel < 62) op = int'($urandom_range(16, 21));
        else if (sel < 70) op = OP_WAIT_CYCLE;
        else if (sel < 80) op = OP_REPEAT;
        else if (sel < 92) op = OP_CONT;
        else if (sel < 96) op = int'($urandom_range(37, 63));
        else op = OP_END;
        rom[(entry + j) % 256] = op[5:0];
      end
      rom[(entry + len) % 256] = 6'd0;
      run_model("rand", entry, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
